change_dispenser: RTL and testbench



---
 rtl/change_dispenser.sv | 162 ++++++++++++++++
 tb/tb_change_dispenser.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//   Turns per-sale change requests into single-nickel ejections. Each sale
//   pulse adds its change count to a saturating pending-nickel accumulator.
//   The FSM then fires the ejector solenoid one coin at a time. It waits
//   for the drop sensor to confirm each coin before firing the next one.
//   If a confirmation is missing, the FSM latches a fault and stops.
//
// Ports
//   clk, rst_n       : clock (rising edge), async active-low reset
//   i_soda, i_change : sale pulse and its change in nickels
//   i_coin_sensed    : drop-sensor pulse, one per ejected nickel
//   o_eject          : solenoid drive, high for PULSE_CYC cycles per coin
//   o_pending        : nickels still owed
//   o_busy           : FSM not idle, or nickels still owed
//   o_overflow       : sticky, accumulator clamped at least once
//   o_fault          : sticky, coin not confirmed within TIMEOUT_CYC
module change_dispenser #(
  parameter int CHG_W       = 3,
  parameter int CNT_W       = 5,
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_soda,
  input  logic [CHG_W-1:0] i_change,
  input  logic             i_coin_sensed,
  output logic             o_eject,
  output logic [CNT_W-1:0] o_pending,
  output logic             o_busy,
  output logic             o_overflow,
  output logic             o_fault
);

  localparam int TMAX_A = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMAX   = (TMAX_A > TIMEOUT_CYC) ? TMAX_A : TIMEOUT_CYC;
  localparam int TW     = $clog2(TMAX + 1);
  // One spare bit so the raw sum cannot wrap before we clamp it.
  localparam int SUM_W  = ((CNT_W > CHG_W) ? CNT_W : CHG_W) + 1;

  localparam logic [TW-1:0]    T_PULSE   = TW'(PULSE_CYC);
  localparam logic [TW-1:0]    T_GAP     = TW'(GAP_CYC);
  localparam logic [TW-1:0]    T_TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [SUM_W-1:0] PEND_MAX  = SUM_W'({CNT_W{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PULSE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_GAP      = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             eject_q, eject_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic             fault_q, fault_d;

  logic             dec;
  logic [SUM_W-1:0] add;
  logic [SUM_W-1:0] sum;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dec     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          state_d = S_PULSE;
          timer_d = T_PULSE;
        end
      end
      // The timer counts down the remaining pulse cycles. The exit happens
      // on the edge where it reads 1. That gives exactly PULSE_CYC high cycles.
      S_PULSE: begin
        if (timer_q <= TW'(1)) begin
          state_d = S_WAIT_ACK;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      // The timer counts up the WAIT_ACK edges already spent. The
      // TIMEOUT_CYC-th edge with no sensor pulse moves the FSM to FAULT.
      S_WAIT_ACK: begin
        if (i_coin_sensed) begin
          dec     = (pending_q != '0);
          state_d = S_GAP;
          timer_d = T_GAP;
        end else if (timer_q >= T_TO_LAST) begin
          state_d = S_FAULT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_GAP: begin
        if (timer_q <= TW'(1)) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // When a capture and a decrement land on the same edge, both are applied.
    add = i_soda ? SUM_W'(i_change) : '0;
    sum = SUM_W'(pending_q) + add - SUM_W'(dec);
    if (sum > PEND_MAX) begin
      pending_d  = '1;
      overflow_d = 1'b1;
    end else begin
      pending_d  = sum[CNT_W-1:0];
      overflow_d = overflow_q;
    end

    eject_d = (state_d == S_PULSE);
    fault_d = fault_q | (state_d == S_FAULT);
    busy_d  = (state_d != S_IDLE) || (pending_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      eject_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      eject_q    <= eject_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      fault_q    <= fault_d;
    end
  end

  assign o_eject    = eject_q;
  assign o_pending  = pending_q;
  assign o_busy     = busy_q;
  assign o_overflow = overflow_q;
  assign o_fault    = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser. The main instance uses the default parameters.
// A second instance uses CNT_W=3 to exercise saturation. The expected length
// of each ejector pulse, and the spacing between pulses, are queued when the
// sale is driven. An eject monitor pops and compares them as the pulses appear.
module tb_change_dispenser;
  localparam int PULSE_CYC   = 4;
  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int PERIOD      = PULSE_CYC + 1 + GAP_CYC + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_soda = 1'b0;
  logic [2:0] i_change = '0;
  logic       i_coin_sensed = 1'b0;
  logic       o_eject, o_busy, o_overflow, o_fault;
  logic [4:0] o_pending;

  logic       soda2 = 1'b0;
  logic [2:0] change2 = '0;
  logic       sensed2 = 1'b0;
  logic       eject2, busy2, ovf2, fault2;
  logic [2:0] pending2;

  change_dispenser #(.CHG_W(3), .CNT_W(5), .PULSE_CYC(PULSE_CYC),
                     .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .i_soda(i_soda), .i_change(i_change),
    .i_coin_sensed(i_coin_sensed), .o_eject(o_eject), .o_pending(o_pending),
    .o_busy(o_busy), .o_overflow(o_overflow), .o_fault(o_fault));

  change_dispenser #(.CHG_W(3), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .i_soda(soda2), .i_change(change2),
    .i_coin_sensed(sensed2), .o_eject(eject2), .o_pending(pending2),
    .o_busy(busy2), .o_overflow(ovf2), .o_fault(fault2));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // scoreboard: expected pulse lengths and rise-to-rise periods
  int q_len[$];
  int q_per[$];

  int  hi_len = 0;
  int  rise_cnt = 0;
  int  last_rise = 0;
  bit  have_last = 1'b0;
  logic eject_prev = 1'b0;

  always @(negedge clk) begin
    if (o_eject) hi_len++;
    if (o_eject && !eject_prev) begin
      rise_cnt++;
      if (have_last && q_per.size() > 0) chk("period", cyc - last_rise, q_per.pop_front());
      last_rise = cyc;
      have_last = 1'b1;
    end
    if (!o_eject && eject_prev) begin
      if (q_len.size() > 0) chk("pulse_len", hi_len, q_len.pop_front());
      else chk("unexpected_pulse", hi_len, 0);
      hi_len = 0;
    end
    eject_prev = o_eject;
  end

  task automatic sale(input int ch);
    i_soda = 1'b1; i_change = 3'(ch);
    @(negedge clk);
    i_soda = 1'b0; i_change = '0;
  endtask

  task automatic sale2(input int ch);
    soda2 = 1'b1; change2 = 3'(ch);
    @(negedge clk);
    soda2 = 1'b0; change2 = '0;
  endtask

  task automatic wait_eject(input logic lvl, input string tag);
    int n = 0;
    while (o_eject !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(o_eject), int'(lvl));
  endtask

  initial begin
    // reset held while a sale is presented
    i_soda = 1'b1; i_change = 3'd5;
    repeat (3) @(negedge clk);
    chk("rst_eject", o_eject, 0);
    chk("rst_pending", o_pending, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_fault", o_fault, 0);
    i_soda = 1'b0; i_change = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_pending", o_pending, 0);
    chk("post_rst_busy", o_busy, 0);

    // saturation on the 3-bit accumulator
    sale2(7);
    chk("sat_pend1", pending2, 7);
    chk("sat_ovf1", ovf2, 0);
    sale2(7);
    chk("sat_pend2", pending2, 7);
    chk("sat_ovf2", ovf2, 1);
    repeat (5) @(negedge clk);
    chk("sat_ovf_sticky", ovf2, 1);

    // zero change, then stray sensor pulses in IDLE
    sale(0);
    for (int i = 0; i < 3; i++) begin
      i_coin_sensed = 1'b1; @(negedge clk);
      i_coin_sensed = 1'b0; @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("zero_rises", rise_cnt, 0);
    chk("zero_pending", o_pending, 0);
    chk("zero_busy", o_busy, 0);

    // single sale of 3, acked on the first WAIT_ACK cycle
    for (int i = 0; i < 3; i++) q_len.push_back(PULSE_CYC);
    for (int i = 0; i < 2; i++) q_per.push_back(PERIOD);
    sale(3);
    chk("single_pend_cap", o_pending, 3);
    for (int k = 0; k < 3; k++) begin
      wait_eject(1'b1, "single_rise");
      wait_eject(1'b0, "single_fall");
      i_coin_sensed = 1'b1;
      @(negedge clk);
      i_coin_sensed = 1'b0;
      chk("single_pend_step", o_pending, 2 - k);
    end
    chk("single_busy_gap", o_busy, 1);
    repeat (2) @(negedge clk);
    chk("single_busy_done", o_busy, 0);
    chk("single_rises", rise_cnt, 3);

    // capture and ack on the same edge
    q_len.push_back(PULSE_CYC);
    sale(2);
    chk("sim_pend_cap", o_pending, 2);
    wait_eject(1'b1, "sim_rise");
    wait_eject(1'b0, "sim_fall");
    i_soda = 1'b1; i_change = 3'd3; i_coin_sensed = 1'b1;
    @(negedge clk);
    i_soda = 1'b0; i_change = '0; i_coin_sensed = 1'b0;
    chk("sim_pending", o_pending, 4);
    rst_n = 1'b0;
    #1;
    chk("sim_rst_pending", o_pending, 0);
    chk("sim_rst_busy", o_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // timeout into FAULT, captures continue, then reset mid-FAULT
    q_len.push_back(PULSE_CYC);
    sale(2);
    wait_eject(1'b1, "to_rise");
    wait_eject(1'b0, "to_fall");
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    chk("to_fault_early", o_fault, 0);
    @(negedge clk);
    chk("to_fault", o_fault, 1);
    chk("to_eject", o_eject, 0);
    chk("to_pending", o_pending, 2);
    chk("to_busy", o_busy, 1);
    sale(3);
    chk("fault_capture", o_pending, 5);
    repeat (3) @(negedge clk);
    chk("fault_sticky", o_fault, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("frst_fault", o_fault, 0);
    chk("frst_pending", o_pending, 0);
    chk("frst_busy", o_busy, 0);
    chk("frst_eject", o_eject, 0);
    chk("frst_ovf", o_overflow, 0);
    @(negedge clk);

    chk("len_queue_left", q_len.size(), 0);
    chk("per_queue_left", q_per.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
